serial_subtractor: RTL

Bit-serial W-bit subtractor that computes diff = a - b (mod 2^W) and a borrow-out flag.
- Processes one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Start/ready/done handshake lets a controller or testbench issue back-to-back operations.
- Complements the existing combinational ripple-carry adder; the two are cross-checked (a - b + b == a) in system benches.

---
 rtl/serial_sub_pkg.sv | 10 +
 rtl/full_subtractor.sv | 18 +
 rtl/serial_subtractor.sv | 106 ++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor and related arithmetic blocks.
package serial_sub_pkg;

    // Controller states: waiting for a request, or shifting bits through the cell.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out bo.
// Kept separate so a parallel ripple subtractor can chain the same cell.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    // Difference bit is the three-way parity; a borrow is needed when y
    // exceeds x, or when they are equal and a borrow is already pending.
    always_comb begin
        d  = x ^ y ^ bin;
        bo = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: diff = a - b (mod 2^W), bout = (a < b).
// One bit per clock, LSB first, through a single full-subtractor cell.
module serial_subtractor #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
);

    import serial_sub_pkg::*;

    // Counter only needs to reach W-1; guard the degenerate log of 1.
    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    sub_state_t     state_reg;
    logic [W-1:0]   a_sh_reg;
    logic [W-1:0]   b_sh_reg;
    // Holds the W-1 difference bits produced so far; the final bit is
    // merged in combinationally on the last edge.
    logic [W-2:0]   res_reg;
    logic           br_reg;
    logic [CW-1:0]  cnt_reg;
    logic [W-1:0]   diff_reg;
    logic           bout_reg;
    logic           done_reg;

    logic           d_bit;
    logic           bo_bit;
    logic [W-1:0]   res_next;

    full_subtractor u_fs (
        .x   (a_sh_reg[0]),
        .y   (b_sh_reg[0]),
        .bin (br_reg),
        .d   (d_bit),
        .bo  (bo_bit)
    );

    // New difference bit enters at the MSB end so that after W bits the
    // LSB-first stream lands in natural bit order.
    always_comb begin
        res_next = {d_bit, res_reg};
    end

    // FSM, operand shifting, borrow chain and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            res_reg   <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            diff_reg  <= '0;
            bout_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        br_reg    <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_sh_reg <= {1'b0, a_sh_reg[W-1:1]};
                    b_sh_reg <= {1'b0, b_sh_reg[W-1:1]};
                    br_reg   <= bo_bit;
                    res_reg  <= res_next[W-1:1];
                    if (cnt_reg == LAST_BIT) begin
                        // Last bit: publish result and borrow, free the unit.
                        diff_reg  <= res_next;
                        bout_reg  <= bo_bit;
                        done_reg  <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ready = (state_reg == IDLE);
    assign done  = done_reg;
    assign diff  = diff_reg;
    assign bout  = bout_reg;

    // An unknown request would make acceptance ambiguous.
    start_known_a : assert property (@(posedge clk) disable iff (rst) !$isunknown(start));

endmodule
